// File: rtl/apb_event_unit_mc_if.sv
// APB slave bus bundle for the multi-core event unit.
interface apb_event_unit_mc_if #(
   parameter int APB_ADDR_WIDTH = 12
);
   logic [APB_ADDR_WIDTH-1:0] PADDR;
   logic [31:0]               PWDATA;
   logic                      PWRITE;
   logic                      PSEL;
   logic                      PENABLE;
   logic [31:0]               PRDATA;
   logic                      PREADY;
   logic                      PSLVERR;

   modport master (
      output PADDR, PWDATA, PWRITE, PSEL, PENABLE,
      input  PRDATA, PREADY, PSLVERR
   );

   modport slave (
      input  PADDR, PWDATA, PWRITE, PSEL, PENABLE,
      output PRDATA, PREADY, PSLVERR
   );
endinterface

// File: rtl/apb_event_unit_mc.sv
// Multi-core event/interrupt/sleep controller. Each core owns a bank of
// interrupt and event mask/pending registers, a lowest-index interrupt
// priority encoder with acknowledge, and a sleep FSM that drains the core,
// gates its clock and wakes it on any enabled interrupt or event.
module apb_event_unit_mc #(
   parameter int APB_ADDR_WIDTH = 12,
   parameter int NB_CORES       = 2,
   parameter int NB_LINES       = 32,
   parameter int ID_W           = $clog2(NB_LINES)
) (
   input  logic                     HCLK,
   input  logic                     HRESET,
   apb_event_unit_mc_if.slave       apb,
   input  logic [NB_LINES-1:0]      irq_i,
   input  logic [NB_LINES-1:0]      event_i,
   output logic [NB_CORES-1:0]      irq_req_o,
   output logic [NB_CORES*ID_W-1:0] irq_id_o,
   input  logic [NB_CORES-1:0]      irq_ack_i,
   input  logic [NB_CORES*ID_W-1:0] irq_ack_id_i,
   input  logic [NB_CORES-1:0]      core_busy_i,
   output logic [NB_CORES-1:0]      fetch_enable_o,
   output logic [NB_CORES-1:0]      core_clk_en_o
);

   localparam logic [3:0] REG_IRQ_MASK = 4'd0;
   localparam logic [3:0] REG_IRQ_PEND = 4'd1;
   localparam logic [3:0] REG_IRQ_SET  = 4'd2;
   localparam logic [3:0] REG_EVT_MASK = 4'd3;
   localparam logic [3:0] REG_EVT_PEND = 4'd4;
   localparam logic [3:0] REG_SLEEP    = 4'd5;
   localparam logic [3:0] REG_STATUS   = 4'd6;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DRAIN = 2'd1,
      ST_SLEEP = 2'd2,
      ST_WAKE  = 2'd3
   } state_e;

   // Lowest set index of v; 0 when v is empty.
   function automatic logic [ID_W-1:0] lowest_idx(input logic [NB_LINES-1:0] v);
      logic [ID_W-1:0] idx;
      idx = '0;
      for (int i = NB_LINES - 1; i >= 0; i--) begin
         if (v[i]) idx = ID_W'(i);
      end
      return idx;
   endfunction

   // One-hot line vector for an ID; IDs beyond the line count select nothing.
   function automatic logic [NB_LINES-1:0] id_onehot(input logic [ID_W-1:0] id);
      logic [NB_LINES-1:0] oh;
      oh = '0;
      for (int i = 0; i < NB_LINES; i++) begin
         if (ID_W'(i) == id) oh[i] = 1'b1;
      end
      return oh;
   endfunction

   logic [APB_ADDR_WIDTH-1:0] paddr_w;
   logic [3:0]                core_idx;
   logic [3:0]                reg_idx;
   logic                      addr_ok;
   logic                      wr_en;
   logic [NB_LINES-1:0]       wdata_l;
   logic                      unused_bits;

   logic [NB_LINES-1:0] irq_mask_q [NB_CORES];
   logic [NB_LINES-1:0] irq_mask_d [NB_CORES];
   logic [NB_LINES-1:0] irq_pend_q [NB_CORES];
   logic [NB_LINES-1:0] irq_pend_d [NB_CORES];
   logic [NB_LINES-1:0] evt_mask_q [NB_CORES];
   logic [NB_LINES-1:0] evt_mask_d [NB_CORES];
   logic [NB_LINES-1:0] evt_pend_q [NB_CORES];
   logic [NB_LINES-1:0] evt_pend_d [NB_CORES];
   state_e              state_q    [NB_CORES];
   state_e              state_d    [NB_CORES];

   logic [NB_CORES-1:0] req_w;
   logic [NB_CORES-1:0] wake_w;
   logic [NB_CORES-1:0] sleep_wr;
   logic [ID_W-1:0]     id_w [NB_CORES];

   logic [31:0]         rdata;
   logic                slverr;

   assign paddr_w     = apb.PADDR;
   assign core_idx    = paddr_w[9:6];
   assign reg_idx     = paddr_w[5:2];
   assign addr_ok     = ({1'b0, core_idx} < 5'(NB_CORES)) && (reg_idx <= REG_STATUS);
   assign wr_en       = apb.PSEL & apb.PENABLE & apb.PWRITE & addr_ok;
   assign wdata_l     = apb.PWDATA[NB_LINES-1:0];
   assign unused_bits = ^{paddr_w[1:0], paddr_w[APB_ADDR_WIDTH-1:10], apb.PWDATA};

   // Per-core request, winning ID and wake condition from the current registers.
   always_comb begin
      req_w     = '0;
      wake_w    = '0;
      irq_req_o = '0;
      irq_id_o  = '0;
      for (int c = 0; c < NB_CORES; c++) begin
         id_w[c]                     = lowest_idx(irq_pend_q[c] & irq_mask_q[c]);
         req_w[c]                    = |(irq_pend_q[c] & irq_mask_q[c]);
         wake_w[c]                   = req_w[c] | (|(evt_pend_q[c] & evt_mask_q[c]));
         irq_req_o[c]                = req_w[c];
         irq_id_o[c*ID_W +: ID_W]    = id_w[c];
      end
   end

   // Register next-state: software clears first, then software set, then the
   // hardware line set, so a line pulse always survives a same-cycle clear.
   always_comb begin
      irq_mask_d = irq_mask_q;
      irq_pend_d = irq_pend_q;
      evt_mask_d = evt_mask_q;
      evt_pend_d = evt_pend_q;
      sleep_wr   = '0;
      for (int c = 0; c < NB_CORES; c++) begin
         if (wr_en && core_idx == 4'(c)) begin
            case (reg_idx)
               REG_IRQ_MASK: irq_mask_d[c] = wdata_l;
               REG_IRQ_PEND: irq_pend_d[c] = irq_pend_d[c] & ~wdata_l;
               REG_EVT_MASK: evt_mask_d[c] = wdata_l;
               REG_EVT_PEND: evt_pend_d[c] = evt_pend_d[c] & ~wdata_l;
               REG_SLEEP:    sleep_wr[c]   = 1'b1;
               default: ;
            endcase
         end
         if (irq_ack_i[c]) begin
            irq_pend_d[c] = irq_pend_d[c] & ~id_onehot(irq_ack_id_i[c*ID_W +: ID_W]);
         end
         if (wr_en && core_idx == 4'(c) && reg_idx == REG_IRQ_SET) begin
            irq_pend_d[c] = irq_pend_d[c] | wdata_l;
         end
         irq_pend_d[c] = irq_pend_d[c] | irq_i;
         evt_pend_d[c] = evt_pend_d[c] | event_i;
      end
   end

   // Sleep FSM next state and Moore outputs {fetch enable, clock enable}.
   always_comb begin
      state_d        = state_q;
      fetch_enable_o = '0;
      core_clk_en_o  = '1;
      for (int c = 0; c < NB_CORES; c++) begin
         case (state_q[c])
            ST_RUN: begin
               fetch_enable_o[c] = 1'b1;
               if (sleep_wr[c] && !wake_w[c]) state_d[c] = ST_DRAIN;
            end
            ST_DRAIN: begin
               if (wake_w[c])                state_d[c] = ST_RUN;
               else if (!core_busy_i[c])     state_d[c] = ST_SLEEP;
            end
            ST_SLEEP: begin
               core_clk_en_o[c] = 1'b0;
               if (wake_w[c]) state_d[c] = ST_WAKE;
            end
            ST_WAKE: begin
               state_d[c] = ST_RUN;
            end
            default: state_d[c] = ST_RUN;
         endcase
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         for (int c = 0; c < NB_CORES; c++) begin
            irq_mask_q[c] <= '0;
            irq_pend_q[c] <= '0;
            evt_mask_q[c] <= '0;
            evt_pend_q[c] <= '0;
            state_q[c]    <= ST_RUN;
         end
      end else begin
         irq_mask_q <= irq_mask_d;
         irq_pend_q <= irq_pend_d;
         evt_mask_q <= evt_mask_d;
         evt_pend_q <= evt_pend_d;
         state_q    <= state_d;
      end
   end

   // APB read mux and error flag; invalid accesses return zero.
   always_comb begin
      rdata  = '0;
      slverr = 1'b0;
      if (apb.PSEL) begin
         if (!addr_ok) begin
            slverr = 1'b1;
         end else begin
            for (int c = 0; c < NB_CORES; c++) begin
               if (core_idx == 4'(c)) begin
                  case (reg_idx)
                     REG_IRQ_MASK: rdata = 32'(irq_mask_q[c]);
                     REG_IRQ_PEND: rdata = 32'(irq_pend_q[c]);
                     REG_EVT_MASK: rdata = 32'(evt_mask_q[c]);
                     REG_EVT_PEND: rdata = 32'(evt_pend_q[c]);
                     REG_STATUS: begin
                        rdata[1:0]        = state_q[c];
                        rdata[8]          = req_w[c];
                        rdata[16 +: ID_W] = id_w[c];
                     end
                     default: ;
                  endcase
               end
            end
         end
      end
   end

   assign apb.PRDATA  = rdata;
   assign apb.PREADY  = 1'b1;
   assign apb.PSLVERR = slverr;

endmodule

// File: tb/tb_apb_event_unit_mc.sv
// Randomized self-checking bench for apb_event_unit_mc with a behavioural
// reference model and a per-cycle output comparator.
module tb_apb_event_unit_mc;
   localparam int NC = 2;
   localparam int NL = 32;
   localparam int IW = 5;

   logic             HCLK = 1'b0;
   logic             HRESET;
   logic [NL-1:0]    irq_i, event_i;
   logic [NC-1:0]    irq_req_o, irq_ack_i, core_busy_i, fetch_enable_o, core_clk_en_o;
   logic [NC*IW-1:0] irq_id_o, irq_ack_id_i;

   apb_event_unit_mc_if #(.APB_ADDR_WIDTH(12)) bus ();

   apb_event_unit_mc #(
      .APB_ADDR_WIDTH(12), .NB_CORES(NC), .NB_LINES(NL)
   ) dut (
      .HCLK(HCLK), .HRESET(HRESET), .apb(bus),
      .irq_i(irq_i), .event_i(event_i),
      .irq_req_o(irq_req_o), .irq_id_o(irq_id_o),
      .irq_ack_i(irq_ack_i), .irq_ack_id_i(irq_ack_id_i),
      .core_busy_i(core_busy_i),
      .fetch_enable_o(fetch_enable_o), .core_clk_en_o(core_clk_en_o)
   );

   always #5 HCLK = ~HCLK;

   int n_chk  = 0;
   int n_pass = 0;
   bit cmp_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
   endtask

   // Reference model: per-core register contents and sleep state (0 run,
   // 1 drain, 2 sleep, 3 wake).
   logic [31:0] m_mask [NC];
   logic [31:0] m_pend [NC];
   logic [31:0] m_emask[NC];
   logic [31:0] m_epend[NC];
   int          m_st   [NC];

   function automatic int m_id(input int c);
      logic [31:0] v;
      v = m_pend[c] & m_mask[c];
      for (int i = 0; i < NL; i++) if (v[i]) return i;
      return 0;
   endfunction

   function automatic bit m_req(input int c);
      return (m_pend[c] & m_mask[c]) != 0;
   endfunction

   function automatic bit m_wake(input int c);
      return m_req(c) || ((m_epend[c] & m_emask[c]) != 0);
   endfunction

   function automatic bit addr_valid(input logic [11:0] a);
      return (int'(a[9:6]) < NC) && (int'(a[5:2]) <= 6);
   endfunction

   function automatic logic [31:0] exp_prdata();
      int c, r;
      if (!bus.PSEL || !addr_valid(bus.PADDR)) return 32'h0;
      c = int'(bus.PADDR[9:6]);
      r = int'(bus.PADDR[5:2]);
      case (r)
         0: return m_mask[c];
         1: return m_pend[c];
         3: return m_emask[c];
         4: return m_epend[c];
         6: return (32'(m_id(c)) << 16) | (32'(m_req(c)) << 8) | 32'(m_st[c]);
         default: return 32'h0;
      endcase
   endfunction

   task automatic model_step();
      logic [31:0] np, nep;
      bit wr, own;
      int core, r;
      if (HRESET) begin
         for (int c = 0; c < NC; c++) begin
            m_mask[c] = 0; m_pend[c] = 0; m_emask[c] = 0; m_epend[c] = 0; m_st[c] = 0;
         end
         return;
      end
      core = int'(bus.PADDR[9:6]);
      r    = int'(bus.PADDR[5:2]);
      wr   = bus.PSEL && bus.PENABLE && bus.PWRITE && addr_valid(bus.PADDR);
      for (int c = 0; c < NC; c++) begin
         bit wk;
         wk  = m_wake(c);
         own = wr && (core == c);
         np  = m_pend[c];
         nep = m_epend[c];
         if (own && r == 0) m_mask[c]  = bus.PWDATA;
         if (own && r == 3) m_emask[c] = bus.PWDATA;
         if (own && r == 1) np  = np & ~bus.PWDATA;
         if (own && r == 4) nep = nep & ~bus.PWDATA;
         if (irq_ack_i[c]) np = np & ~(32'd1 << irq_ack_id_i[c*IW +: IW]);
         if (own && r == 2) np = np | bus.PWDATA;
         m_pend[c]  = np | irq_i;
         m_epend[c] = nep | event_i;
         case (m_st[c])
            0: if (own && r == 5 && !wk) m_st[c] = 1;
            1: if (wk) m_st[c] = 0; else if (!core_busy_i[c]) m_st[c] = 2;
            2: if (wk) m_st[c] = 3;
            default: m_st[c] = 0;
         endcase
      end
   endtask

   always @(posedge HCLK) model_step();

   // Per-cycle comparison of every output against the model.
   always @(negedge HCLK) begin
      if (cmp_en) begin
         for (int c = 0; c < NC; c++) begin
            check($sformatf("req%0d", c),   32'(irq_req_o[c]),          32'(m_req(c)));
            check($sformatf("id%0d", c),    32'(irq_id_o[c*IW +: IW]),  32'(m_id(c)));
            check($sformatf("fetch%0d", c), 32'(fetch_enable_o[c]),     32'(m_st[c] == 0));
            check($sformatf("clken%0d", c), 32'(core_clk_en_o[c]),      32'(m_st[c] != 2));
         end
         check("prdata",  bus.PRDATA,         exp_prdata());
         check("pslverr", 32'(bus.PSLVERR),   32'(bus.PSEL && !addr_valid(bus.PADDR)));
         check("pready",  32'(bus.PREADY),    32'h1);
      end
   end

   task automatic step();
      @(posedge HCLK);
      #1;
   endtask

   task automatic apb_write(input logic [11:0] a, input logic [31:0] d);
      bus.PSEL = 1'b1; bus.PWRITE = 1'b1; bus.PADDR = a; bus.PWDATA = d; bus.PENABLE = 1'b0;
      step();
      bus.PENABLE = 1'b1;
      step();
      bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
   endtask

   task automatic apb_read(input logic [11:0] a, output logic [31:0] d, output logic err);
      bus.PSEL = 1'b1; bus.PWRITE = 1'b0; bus.PADDR = a; bus.PENABLE = 1'b0;
      step();
      bus.PENABLE = 1'b1;
      @(negedge HCLK);
      d   = bus.PRDATA;
      err = bus.PSLVERR;
      step();
      bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
   endtask

   task automatic rd_chk(input string name, input logic [11:0] a, input logic [31:0] exp);
      logic [31:0] d;
      logic e;
      apb_read(a, d, e);
      check(name, d, exp);
      check({name, "_err"}, 32'(e), 32'h0);
   endtask

   task automatic err_chk(input string name, input logic [11:0] a);
      logic [31:0] d;
      logic e;
      bus.PSEL = 1'b1; bus.PWRITE = 1'b0; bus.PADDR = a; bus.PENABLE = 1'b0;
      step();
      bus.PENABLE = 1'b1;
      @(negedge HCLK);
      d = bus.PRDATA;
      e = bus.PSLVERR;
      check({name, "_slverr"}, 32'(e), 32'h1);
      check({name, "_pready"}, 32'(bus.PREADY), 32'h1);
      check({name, "_prdata"}, d, 32'h0);
      step();
      bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
   endtask

   task automatic rand_lines();
      irq_i       = ($urandom_range(0, 5) == 0) ? (32'd1 << $urandom_range(0, 31)) : 32'h0;
      event_i     = ($urandom_range(0, 7) == 0) ? (32'd1 << $urandom_range(0, 31)) : 32'h0;
      core_busy_i = NC'($urandom_range(0, 3));
      irq_ack_i   = ($urandom_range(0, 3) == 0) ? NC'($urandom_range(1, 3)) : '0;
      for (int c = 0; c < NC; c++) begin
         irq_ack_id_i[c*IW +: IW] = ($urandom_range(0, 1) == 0) ? IW'(m_id(c))
                                                               : IW'($urandom_range(0, 31));
      end
   endtask

   initial begin
      logic [31:0] d;
      logic [11:0] a;
      HRESET = 1'b1;
      irq_i = '0; event_i = '0; irq_ack_i = '0; irq_ack_id_i = '0; core_busy_i = '0;
      bus.PADDR = '0; bus.PWDATA = '0; bus.PWRITE = 1'b0; bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
      step();
      cmp_en = 1'b1;
      @(negedge HCLK);
      check("rst_fetch", 32'(fetch_enable_o), 32'h3);
      check("rst_clken", 32'(core_clk_en_o),  32'h3);
      check("rst_req",   32'(irq_req_o),      32'h0);
      check("rst_id",    32'(irq_id_o),       32'h0);
      check("rst_prdata", bus.PRDATA,         32'h0);
      check("rst_slverr", 32'(bus.PSLVERR),   32'h0);
      step();
      HRESET = 1'b0;

      // Priority and acknowledge
      apb_write(12'h000, 32'h0000_00F0);
      irq_i = 32'h0000_0030;
      step();
      irq_i = '0;
      @(negedge HCLK);
      check("prio_req0", 32'(irq_req_o[0]),   32'h1);
      check("prio_id0",  32'(irq_id_o[4:0]),  32'd4);
      check("prio_req1", 32'(irq_req_o[1]),   32'h0);
      irq_ack_i = 2'b01; irq_ack_id_i = {5'd0, 5'd4};
      step();
      irq_ack_i = '0;
      @(negedge HCLK);
      check("ack4_id0",  32'(irq_id_o[4:0]), 32'd5);
      check("ack4_req0", 32'(irq_req_o[0]),  32'h1);
      irq_ack_i = 2'b01; irq_ack_id_i = {5'd0, 5'd5};
      step();
      irq_ack_i = '0;
      @(negedge HCLK);
      check("ack5_req0", 32'(irq_req_o[0]), 32'h0);
      rd_chk("ack5_pend0", 12'h004, 32'h0);
      rd_chk("core1_pend", 12'h044, 32'h0000_0030);

      // Hardware set beats a same-cycle write-1-to-clear
      bus.PSEL = 1'b1; bus.PWRITE = 1'b1; bus.PADDR = 12'h004; bus.PWDATA = 32'h8; bus.PENABLE = 1'b0;
      step();
      bus.PENABLE = 1'b1; irq_i = 32'h8;
      step();
      irq_i = '0; bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
      rd_chk("collide_pend", 12'h004, 32'h0000_0008);
      apb_write(12'h004, 32'h8);
      rd_chk("w1c_pend", 12'h004, 32'h0);

      // Sleep request ignored while an enabled interrupt is pending
      apb_write(12'h000, 32'h4);
      apb_write(12'h008, 32'h4);
      apb_write(12'h014, 32'h0);
      @(negedge HCLK);
      check("ign_fetch0", 32'(fetch_enable_o[0]), 32'h1);
      rd_chk("ign_status", 12'h018, 32'h0002_0100);
      apb_write(12'h004, 32'h4);
      apb_write(12'h000, 32'h0);

      // Drain, sleep and event wake
      core_busy_i = 2'b01;
      apb_write(12'h00C, 32'h1);
      apb_write(12'h014, 32'h0);
      @(negedge HCLK);
      check("drain_fetch0", 32'(fetch_enable_o[0]), 32'h0);
      check("drain_clken0", 32'(core_clk_en_o[0]),  32'h1);
      step(); step();
      @(negedge HCLK);
      check("busy_clken0", 32'(core_clk_en_o[0]), 32'h1);
      core_busy_i = 2'b00;
      step();
      @(negedge HCLK);
      check("sleep_clken0", 32'(core_clk_en_o[0]),  32'h0);
      check("sleep_fetch0", 32'(fetch_enable_o[0]), 32'h0);
      rd_chk("sleep_status", 12'h018, 32'h2);
      event_i = 32'h1;
      step();
      event_i = '0;
      @(negedge HCLK);
      check("pend_clken0", 32'(core_clk_en_o[0]), 32'h0);
      step();
      @(negedge HCLK);
      check("wake_fetch0", 32'(fetch_enable_o[0]), 32'h0);
      check("wake_clken0", 32'(core_clk_en_o[0]),  32'h1);
      step();
      @(negedge HCLK);
      check("run_fetch0", 32'(fetch_enable_o[0]), 32'h1);
      check("run_clken0", 32'(core_clk_en_o[0]),  32'h1);
      check("evt_noreq0", 32'(irq_req_o[0]),      32'h0);
      apb_write(12'h010, 32'h1);
      apb_write(12'h00C, 32'h0);

      // Reset while core 1 sleeps
      apb_write(12'h040, 32'h1);
      apb_write(12'h054, 32'h0);
      step();
      @(negedge HCLK);
      check("c1_sleep_clken", 32'(core_clk_en_o[1]), 32'h0);
      HRESET = 1'b1;
      step();
      @(negedge HCLK);
      check("c1_rst_fetch", 32'(fetch_enable_o[1]), 32'h1);
      check("c1_rst_clken", 32'(core_clk_en_o[1]),  32'h1);
      HRESET = 1'b0;
      rd_chk("c1_rst_mask",  12'h040, 32'h0);
      rd_chk("c1_rst_pend",  12'h044, 32'h0);
      rd_chk("c1_rst_epend", 12'h050, 32'h0);

      // Bus errors
      apb_write(12'h000, 32'h0000_005A);
      err_chk("core5", 12'h140);
      apb_write(12'h140, 32'hFFFF_FFFF);
      err_chk("off1c", 12'h01C);
      apb_write(12'h01C, 32'hFFFF_FFFF);
      rd_chk("err_nochange", 12'h000, 32'h0000_005A);

      // Randomized traffic
      for (int it = 0; it < 3000; it++) begin
         rand_lines();
         HRESET = ($urandom_range(0, 599) == 0);
         if ($urandom_range(0, 2) == 0) begin
            a = 12'(($urandom_range(0, 3) << 6) | ($urandom_range(0, 8) << 2));
            case ($urandom_range(0, 2))
               0:       d = $urandom();
               1:       d = 32'h0;
               default: d = 32'hFFFF_FFFF;
            endcase
            bus.PSEL = 1'b1; bus.PWRITE = ($urandom_range(0, 2) != 0); bus.PADDR = a;
            bus.PWDATA = d; bus.PENABLE = 1'b0;
            step();
            rand_lines();
            HRESET = 1'b0;
            bus.PENABLE = 1'b1;
            step();
            bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
         end else begin
            step();
         end
      end
      irq_i = '0; event_i = '0; irq_ack_i = '0; HRESET = 1'b0;
      step();
      @(negedge HCLK);
      cmp_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
